// File: rtl/crtc_mode_loader.sv
// rtl/crtc_mode_loader.sv - UM6845R mode-table loader sharing the CRTC write port with the CPU
// Optional feature: CRTC_LOADER_VSYNC_ALIGN_EN holds each load until a vsync rising edge.
module crtc_mode_loader #(
  parameter int NUM_REGS     = 12,
  parameter int AUTOLOAD     = 1,
  parameter int DEFAULT_MODE = 0
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic       vsync,
  output logic       busy,
  output logic       done,
  input  logic       cpu_cs,
  input  logic       cpu_wr,
  input  logic       cpu_rs,
  input  logic [7:0] cpu_di,
  output logic       cpu_wait,
  output logic       crtc_enable,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di
);

  typedef enum logic [2:0] {IDLE, WAIT_VS, ADDR, DATA, RESTORE, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  localparam logic [7:0] MODE_TABLE [4][12] = '{
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C, 8'h02, 8'h07, 8'h06, 8'h07},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70, 8'h02, 8'h01, 8'h06, 8'h07},
    '{8'h38, 8'h28, 8'h2B, 8'h08, 8'h3F, 8'h06, 8'h32, 8'h38, 8'h02, 8'h03, 8'h06, 8'h07}
  };

  state_t     state;
  logic       pend;
  logic       boot;
  logic [1:0] pend_mode;
  logic [1:0] cur_mode;
  logic [3:0] idx;
  logic [4:0] addr_shadow;
  logic       cpu_acc;

`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
  logic       vsync_q;
`else
  logic       unused_vsync;
  assign unused_vsync = vsync;
`endif

  assign busy     = pend | (state != IDLE);
  assign cpu_wait = busy;
  assign cpu_acc  = cpu_cs & ~busy;

  // The state names the transaction currently on the CRTC bus; bus registers are loaded on entry.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      pend        <= 1'b0;
      boot        <= (AUTOLOAD != 0);
      pend_mode   <= 2'd0;
      cur_mode    <= 2'd0;
      idx         <= 4'd0;
      addr_shadow <= 5'd0;
      done        <= 1'b0;
      crtc_enable <= 1'b0;
      crtc_ncs    <= 1'b1;
      crtc_rnw    <= 1'b1;
      crtc_rs     <= 1'b0;
      crtc_di     <= 8'h00;
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
      vsync_q     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      crtc_enable <= 1'b0;
      crtc_ncs    <= 1'b1;
      crtc_rnw    <= 1'b1;
      boot        <= 1'b0;
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
      vsync_q     <= vsync;
`endif
      if (boot) begin
        pend      <= 1'b1;
        pend_mode <= 2'(DEFAULT_MODE);
      end
      case (state)
        IDLE: begin
          if (cpu_acc) begin
            crtc_enable <= 1'b1;
            crtc_ncs    <= 1'b0;
            crtc_rnw    <= ~cpu_wr;
            crtc_rs     <= cpu_rs;
            crtc_di     <= cpu_di;
            if (cpu_wr && !cpu_rs) addr_shadow <= cpu_di[4:0];
          end else if (pend) begin
            pend     <= 1'b0;
            cur_mode <= pend_mode;
            idx      <= 4'd0;
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
            state    <= WAIT_VS;
`else
            state       <= ADDR;
            crtc_enable <= 1'b1;
            crtc_ncs    <= 1'b0;
            crtc_rnw    <= 1'b0;
            crtc_rs     <= 1'b0;
            crtc_di     <= 8'h00;
`endif
          end
        end
`ifdef CRTC_LOADER_VSYNC_ALIGN_EN
        WAIT_VS: begin
          if (vsync && !vsync_q) begin
            state       <= ADDR;
            crtc_enable <= 1'b1;
            crtc_ncs    <= 1'b0;
            crtc_rnw    <= 1'b0;
            crtc_rs     <= 1'b0;
            crtc_di     <= 8'h00;
          end
        end
`endif
        ADDR: begin
          state       <= DATA;
          crtc_enable <= 1'b1;
          crtc_ncs    <= 1'b0;
          crtc_rnw    <= 1'b0;
          crtc_rs     <= 1'b1;
          crtc_di     <= MODE_TABLE[cur_mode][idx];
        end
        DATA: begin
          idx         <= idx + 4'd1;
          crtc_enable <= 1'b1;
          crtc_ncs    <= 1'b0;
          crtc_rnw    <= 1'b0;
          crtc_rs     <= 1'b0;
          if (idx == LAST_IDX) begin
            state   <= RESTORE;
            crtc_di <= {3'b000, addr_shadow};
          end else begin
            state   <= ADDR;
            crtc_di <= {4'b0000, idx + 4'd1};
          end
        end
        RESTORE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A request arriving on the start edge must survive the pend clear above.
      if (mode_req) begin
        pend      <= 1'b1;
        pend_mode <= mode_sel;
      end
    end
  end

endmodule
